// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous data memory.
// Port A (pipeline) has priority; port B (loader/debug) is forced through after STARVE_MAX denials.
module dmem_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = ($clog2(STARVE_MAX + 1) > 2) ? $clog2(STARVE_MAX + 1) : 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        FORCE_B = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    logic              tag_valid;
    logic              tag_is_b;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // State and starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Grant decision, starvation counting and next state
    always_comb begin
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        starve_nxt = '0;
        state_nxt  = IDLE;

        if (rst) begin
            if (state == FORCE_B) begin
                b_gnt = b_req;
            end else if (a_req) begin
                a_gnt = 1'b1;
            end else begin
                b_gnt = b_req;
            end
        end

        if (b_req && !b_gnt) begin
            starve_nxt = (starve_cnt >= CNT_MAX) ? CNT_MAX : starve_cnt + CNT_W'(1);
        end

        if (b_req && (starve_nxt == CNT_MAX)) begin
            state_nxt = FORCE_B;
        end else if (a_gnt) begin
            state_nxt = SERVE_A;
        end else if (b_gnt) begin
            state_nxt = SERVE_B;
        end
    end

    // Memory drive follows the granted port; address/data hold when idle
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (a_gnt) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    // Read tag, held memory drive and last returned data per port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid <= 1'b0;
            tag_is_b  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            tag_valid <= (a_gnt && !a_we) || (b_gnt && !b_we);
            tag_is_b  <= b_gnt;
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            if (a_rvalid) begin
                a_rdata_q <= mem_rdata;
            end
            if (b_rvalid) begin
                b_rdata_q <= mem_rdata;
            end
        end
    end

    assign a_rvalid = tag_valid && !tag_is_b;
    assign b_rvalid = tag_valid && tag_is_b;
    assign a_rdata  = a_rvalid ? mem_rdata : a_rdata_q;
    assign b_rdata  = b_rvalid ? mem_rdata : b_rdata_q;
    assign busy     = rst && (tag_valid || a_req || b_req);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, corner sequences, and random traffic
// checked against a transaction-level model of priority, starvation and memory contents.
module tb_dmem_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned SMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Write-first synchronous memory driven by the DUT
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    typedef struct {
        logic          ar, aw;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          br, bw;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic          e_agnt, e_bgnt, e_we, e_arv;
        logic [DW-1:0] e_ard;
        logic          e_brv;
        logic [DW-1:0] e_brd;
    } vec_t;

    vec_t tbl [12];

    // Reference model state for random traffic
    logic [DW-1:0] ref_mem [16];
    int            starve;
    bit            force_b;
    bit            tag_v, tag_b;
    logic [DW-1:0] tag_d;
    logic [DW-1:0] exp_ard, exp_brd, last_wd;
    logic [AW-1:0] last_addr;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem_rdata = '0;

        tbl[0]  = '{1'b1, 1'b1, 4'd5,  32'h0000_00AA, 1'b0, 1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 4'd5,  32'h0,         1'b0, 1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hAA,   1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b1, 1'b1, 4'd15, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAA,   1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 4'd15, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'hAA,   1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'hAA,   1'b1, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b1, 1'b1, 4'd3,  32'h1234,      1'b0, 1'b1, 1'b1, 1'b0, 32'hAA,   1'b0, 32'hDEAD_BEEF};
        tbl[7]  = '{1'b1, 1'b0, 4'd3,  32'h0,         1'b0, 1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'hAA,   1'b0, 32'hDEAD_BEEF};
        tbl[8]  = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 1'b0, 32'hDEAD_BEEF};
        tbl[9]  = '{1'b1, 1'b1, 4'd7,  32'h55,        1'b0, 1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h1234, 1'b0, 32'hDEAD_BEEF};
        tbl[10] = '{1'b1, 1'b0, 4'd7,  32'h0,         1'b0, 1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 1'b0, 32'hDEAD_BEEF};
        tbl[11] = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h55,   1'b0, 32'hDEAD_BEEF};

        // Reset with both requests high: nothing may be granted
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'd9, 32'h77, 1'b1, 1'b1, 4'd8, 32'h66);
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_a_gnt", a_gnt, 1'b0);
        chk1("rst_b_gnt", b_gnt, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chkw("rst_mem_addr", DW'(mem_addr), '0);
        chkw("rst_mem_wdata", mem_wdata, '0);
        chk1("rst_a_rvalid", a_rvalid, 1'b0);
        chkw("rst_a_rdata", a_rdata, '0);
        chkw("rst_b_rdata", b_rdata, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, '0);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd);
            #1;
            chk1($sformatf("vec%0d_a_gnt", i), a_gnt, tbl[i].e_agnt);
            chk1($sformatf("vec%0d_b_gnt", i), b_gnt, tbl[i].e_bgnt);
            chk1($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].e_we);
            if (tbl[i].e_agnt) chkw($sformatf("vec%0d_mem_addr", i), DW'(mem_addr), DW'(tbl[i].aa));
            if (tbl[i].e_bgnt) chkw($sformatf("vec%0d_mem_addr", i), DW'(mem_addr), DW'(tbl[i].ba));
            chk1($sformatf("vec%0d_a_rvalid", i), a_rvalid, tbl[i].e_arv);
            chkw($sformatf("vec%0d_a_rdata", i), a_rdata, tbl[i].e_ard);
            chk1($sformatf("vec%0d_b_rvalid", i), b_rvalid, tbl[i].e_brv);
            chkw($sformatf("vec%0d_b_rdata", i), b_rdata, tbl[i].e_brd);
        end

        // Both requesting continuously: A,A,A,B repeating
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 4'd1, '0, 1'b1, 1'b0, 4'd2, '0);
            #1;
            chk1($sformatf("starve%0d_a_gnt", i), a_gnt, (i % 4) != 3);
            chk1($sformatf("starve%0d_b_gnt", i), b_gnt, (i % 4) == 3);
        end
        repeat (2) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, '0);
        end

        // B forced, then B withdraws: no grant that cycle, A granted after
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 4'd4, '0, i < 3, 1'b0, 4'd6, '0);
            #1;
            chk1($sformatf("drop%0d_a_gnt", i), a_gnt, i != 3);
            chk1($sformatf("drop%0d_b_gnt", i), b_gnt, 1'b0);
        end
        repeat (2) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, '0);
        end

        // Reset during an outstanding A read
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, 4'd0, '0);
        #1;
        chk1("midrst_a_gnt_pre", a_gnt, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk1("midrst_a_gnt", a_gnt, 1'b0);
        chk1("midrst_a_rvalid", a_rvalid, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_mem_we", mem_we, 1'b0);
        chkw("midrst_mem_addr", DW'(mem_addr), '0);
        chkw("midrst_a_rdata", a_rdata, '0);
        chkw("midrst_b_rdata", b_rdata, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, '0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk1($sformatf("postrst%0d_a_rvalid", i), a_rvalid, 1'b0);
            chk1($sformatf("postrst%0d_b_rvalid", i), b_rvalid, 1'b0);
        end

        // Random traffic against the transaction-level model
        for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
        starve = 0; force_b = 0; tag_v = 0; tag_b = 0; tag_d = '0;
        exp_ard = '0; exp_brd = '0; last_addr = '0; last_wd = '0;
        begin
            bit            pa, pb, paw, pbw, ga, gb, e_we;
            logic [AW-1:0] paa, pba, e_addr;
            logic [DW-1:0] pad, pbd, e_wd;
            int            rate_a, rate_b;
            pa = 0; pb = 0; paw = 0; pbw = 0; paa = '0; pba = '0; pad = '0; pbd = '0;
            rate_a = 50; rate_b = 50;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (cyc % 200 == 0) begin
                    rate_a = $urandom_range(5, 100);
                    rate_b = $urandom_range(5, 100);
                end
                @(negedge clk);
                if (!pa && ($urandom % 100) < rate_a) begin
                    pa = 1; paw = 1'($urandom); paa = AW'($urandom); pad = $urandom;
                end
                if (!pb && ($urandom % 100) < rate_b) begin
                    pb = 1; pbw = 1'($urandom); pba = AW'($urandom); pbd = $urandom;
                end
                drive(pa, pa ? paw : 1'($urandom), pa ? paa : AW'($urandom), pa ? pad : $urandom,
                      pb, pb ? pbw : 1'($urandom), pb ? pba : AW'($urandom), pb ? pbd : $urandom);
                #1;
                ga = pa && !force_b;
                gb = pb && (force_b || !pa);
                e_we   = ga ? paw : (gb ? pbw : 1'b0);
                e_addr = ga ? paa : (gb ? pba : last_addr);
                e_wd   = ga ? pad : (gb ? pbd : last_wd);
                if (tag_v && !tag_b) exp_ard = tag_d;
                if (tag_v && tag_b)  exp_brd = tag_d;
                chk1("rnd_a_gnt", a_gnt, ga);
                chk1("rnd_b_gnt", b_gnt, gb);
                chk1("rnd_mem_we", mem_we, e_we);
                chkw("rnd_mem_addr", DW'(mem_addr), DW'(e_addr));
                chkw("rnd_mem_wdata", mem_wdata, e_wd);
                chk1("rnd_a_rvalid", a_rvalid, tag_v && !tag_b);
                chk1("rnd_b_rvalid", b_rvalid, tag_v && tag_b);
                chkw("rnd_a_rdata", a_rdata, exp_ard);
                chkw("rnd_b_rdata", b_rdata, exp_brd);
                chk1("rnd_busy", busy, tag_v || pa || pb);
                // Advance the model by one granted transaction
                tag_v = (ga && !paw) || (gb && !pbw);
                tag_b = gb;
                tag_d = ref_mem[e_addr];
                if (e_we) ref_mem[e_addr] = e_wd;
                last_addr = e_addr;
                last_wd   = e_wd;
                if (pb && !gb) starve = (starve < int'(SMAX)) ? starve + 1 : int'(SMAX);
                else           starve = 0;
                force_b = pb && (starve == int'(SMAX));
                if (ga) pa = 0;
                if (gb) pb = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width.
REQ-002 SHALL have parameter ADDR_W, default 4: data memory word address width (16 words).
REQ-003 SHALL have parameter STARVE_MAX, default 3: consecutive denied cycles of port B before B is forced.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports a_req/a_we  in  1/1  pipeline memory-stage access request / write qualifier.
REQ-007 SHALL have ports a_addr/a_wdata  in  ADDR_W/DATA_W  pipeline address / store data.
REQ-008 SHALL have ports a_gnt/a_rvalid  out  1/1  pipeline grant (low = stall) / load data valid.
REQ-009 SHALL have port a_rdata  out  DATA_W  load data to pipeline.
REQ-010 SHALL have ports b_req/b_we/b_addr/b_wdata  in  1/1/ADDR_W/DATA_W  loader/debug port request, same meaning as port A.
REQ-011 SHALL have ports b_gnt/b_rvalid/b_rdata  out  1/1/DATA_W  loader/debug grant, valid, data.
REQ-012 SHALL have ports mem_we/mem_addr/mem_wdata  out  1/ADDR_W/DATA_W  drive to the shared data memory.
REQ-013 SHALL have port mem_rdata  in  DATA_W  data memory read data, valid one cycle after address.
REQ-014 SHALL have port busy  out  1  high whenever a read is outstanding or either request is high.

Function
REQ-015 SHALL grant at most one port per cycle; a_gnt and b_gnt are combinational from requests and registered state, never both high.
REQ-016 SHALL serve one access per granted cycle; a requester holds req/we/addr/wdata stable until it sees gnt high in the same cycle.
REQ-017 SHALL give port A priority: a_req=1 grants A unless FSM is in FORCE_B.
REQ-018 SHALL grant B when b_req=1 and (a_req=0 or state FORCE_B).
REQ-019 SHALL keep 2-bit-or-wider starvation counter: increments each cycle b_req=1 and b_gnt=0; clears on b_gnt or b_req=0; saturates at STARVE_MAX.
REQ-020 SHALL run FSM states IDLE, SERVE_A, SERVE_B, FORCE_B; next state = FORCE_B when counter reaches STARVE_MAX while b_req=1, else SERVE_A if A granted, SERVE_B if B granted, else IDLE.
REQ-021 SHALL leave FORCE_B after exactly one B grant; FORCE_B with b_req dropped returns to IDLE without granting B.
REQ-022 SHALL drive mem_addr/mem_wdata/mem_we from the granted port; mem_we = granted port's we; with no grant mem_we=0, mem_addr/mem_wdata hold last values.
REQ-023 SHALL register a read tag (port id + valid) for granted reads; next cycle assert that port's rvalid for one cycle with rdata = mem_rdata.
REQ-024 SHALL keep a_rdata/b_rdata holding last returned value when rvalid low; writes never raise rvalid.
REQ-025 SHALL support back-to-back accesses every cycle, including read-after-write same address (returns newly written data, memory write-first).
REQ-026 SHALL handle simultaneous a_req and b_req in IDLE by granting A and incrementing the counter.

Reset
REQ-027 SHALL on rst=0, immediately and asynchronously: state IDLE, counter 0, read tag invalid, a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, a_rdata=b_rdata=0, busy=0.
REQ-028 SHALL drop an outstanding read tag when reset asserts mid-access; no rvalid after reset release.
REQ-029 SHALL grant nothing during reset, regardless of requests.

Verification
REQ-030 SHALL pass: A write addr 5 = 0x0000_00AA, then A read addr 5 -> mem_we=1 cycle 0; a_rvalid=1 with a_rdata=0xAA one cycle after read grant.
REQ-031 SHALL pass: a_req and b_req held high continuously -> A granted 3 cycles, B granted 4th cycle (FORCE_B), pattern repeats 3:1.
REQ-032 SHALL pass: only b_req, B read addr 15 containing 0xDEAD_BEEF -> b_gnt same cycle, b_rvalid next cycle with 0xDEADBEEF, a_rvalid stays 0.
REQ-033 SHALL pass: A read granted, rst pulled low before next edge -> a_rvalid never asserts, all outputs reset values.
REQ-034 SHALL pass: counter at STARVE_MAX, b_req dropped in FORCE_B, a_req=1 -> no B grant, A granted next cycle, state SERVE_A.
REQ-035 SHALL pass: B write addr 3 = 0x1234 then A read addr 3 next cycle -> a_rdata=0x1234.
